// File: rtl/framebuffer_writer.sv
// Write-side engine for the page-organised 1-bpp framebuffer: pixel set/clear/toggle
// via read-modify-write, plus a whole-screen constant fill.
module framebuffer_writer #(
    parameter int WIDTH     = 160,
    parameter int HEIGHT    = 120,
    parameter int ADDR_BITS = 12
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 CmdValid_i,
    output logic                 CmdReady_o,
    input  logic [1:0]           CmdOp_i,
    input  logic [7:0]           X_i,
    input  logic [6:0]           Y_i,
    input  logic [7:0]           FillData_i,
    output logic [ADDR_BITS-1:0] Address_o,
    output logic [7:0]           DataToRAM_o,
    output logic                 WriteEnable_o,
    input  logic [7:0]           DataFromRAM_i,
    output logic                 Discard_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_MODIFY = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_FILL   = 3'd4;

    localparam logic [1:0] OP_SET   = 2'b00;
    localparam logic [1:0] OP_CLR   = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b11;

    localparam logic [7:0]           X_LIM     = 8'(WIDTH);
    localparam logic [6:0]           Y_LIM     = 7'(HEIGHT);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WIDTH * HEIGHT / 8 - 1);

    logic [2:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic                 discard_q, discard_d;
    logic [1:0]           op_q, op_d;
    logic [2:0]           bit_q, bit_d;

    logic [ADDR_BITS-1:0] pix_addr;
    logic                 in_range;
    logic [7:0]           mask;

    // Page-major layout: each page of 8 rows is one WIDTH-byte strip.
    assign pix_addr = ADDR_BITS'(Y_i[6:3]) * ADDR_BITS'(WIDTH) + ADDR_BITS'(X_i);
    assign in_range = (X_i < X_LIM) && (Y_i < Y_LIM);
    assign mask     = 8'b1 << bit_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        discard_d = 1'b0;
        op_d      = op_q;
        bit_d     = bit_q;
        case (state_q)
            S_IDLE: begin
                if (CmdValid_i) begin
                    if (CmdOp_i == OP_FILL) begin
                        addr_d  = '0;
                        wdata_d = FillData_i;
                        we_d    = 1'b1;
                        state_d = S_FILL;
                    end else if (in_range) begin
                        addr_d  = pix_addr;
                        op_d    = CmdOp_i;
                        bit_d   = Y_i[2:0];
                        state_d = S_READ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
            end
            S_READ:   state_d = S_MODIFY;
            S_MODIFY: begin
                case (op_q)
                    OP_SET:  wdata_d = DataFromRAM_i | mask;
                    OP_CLR:  wdata_d = DataFromRAM_i & ~mask;
                    default: wdata_d = DataFromRAM_i ^ mask;
                endcase
                we_d    = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE:  state_d = S_IDLE;
            S_FILL: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d = addr_q + 1'b1;
                    we_d   = 1'b1;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            discard_q <= 1'b0;
            op_q      <= '0;
            bit_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            discard_q <= discard_d;
            op_q      <= op_d;
            bit_q     <= bit_d;
        end
    end

    assign CmdReady_o    = (state_q == S_IDLE);
    assign Address_o     = addr_q;
    assign DataToRAM_o   = wdata_q;
    assign WriteEnable_o = we_q;
    assign Discard_o     = discard_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Randomised bench for framebuffer_writer: a behavioural RAM plus a reference image
// of the expected framebuffer contents, with every RAM write logged and checked.
module tb_framebuffer_writer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        CmdValid_i;
    logic        CmdReady_o;
    logic [1:0]  CmdOp_i;
    logic [7:0]  X_i;
    logic [6:0]  Y_i;
    logic [7:0]  FillData_i;
    logic [11:0] Address_o;
    logic [7:0]  DataToRAM_o;
    logic        WriteEnable_o;
    logic [7:0]  DataFromRAM_i;
    logic        Discard_o;

    framebuffer_writer dut (
        .Clock(Clock), .Reset(Reset),
        .CmdValid_i(CmdValid_i), .CmdReady_o(CmdReady_o), .CmdOp_i(CmdOp_i),
        .X_i(X_i), .Y_i(Y_i), .FillData_i(FillData_i),
        .Address_o(Address_o), .DataToRAM_o(DataToRAM_o), .WriteEnable_o(WriteEnable_o),
        .DataFromRAM_i(DataFromRAM_i), .Discard_o(Discard_o)
    );

    always #5 Clock = ~Clock;

    logic [7:0] ram [0:4095];
    logic [7:0] ref_img [0:4095];
    int         wq_a[$];
    logic [7:0] wq_d[$];
    int total = 0;
    int bad   = 0;

    // Synchronous-read RAM; writes are logged for the checks.
    always @(posedge Clock) begin
        DataFromRAM_i <= ram[Address_o];
        if (WriteEnable_o) begin
            ram[Address_o] <= DataToRAM_o;
            wq_a.push_back(int'(Address_o));
            wq_d.push_back(DataToRAM_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int lim, output int cyc);
        cyc = 0;
        while (!CmdReady_o && cyc < lim) begin
            @(negedge Clock);
            cyc++;
        end
        chk("ready_timeout", {31'b0, CmdReady_o}, 32'd1);
    endtask

    function automatic logic [7:0] apply_op(input logic [1:0] op, input logic [7:0] b, input int y);
        logic [7:0] m;
        m = 8'(1 << (y % 8));
        if (op == 2'd0) return b | m;
        if (op == 2'd1) return b & ~m;
        return b ^ m;
    endfunction

    task automatic do_pixel(input logic [1:0] op, input int x, input int y);
        int cyc, a;
        logic [7:0] e;
        bit ok;
        ok = (x < 160) && (y < 120);
        a  = (y / 8) * 160 + x;
        wq_a.delete(); wq_d.delete();
        CmdOp_i = op; X_i = 8'(x); Y_i = 7'(y); CmdValid_i = 1'b1;
        chk("ready_before", {31'b0, CmdReady_o}, 32'd1);
        @(negedge Clock);
        CmdValid_i = 1'b0;
        X_i = 8'($urandom); Y_i = 7'($urandom); CmdOp_i = 2'($urandom_range(0, 2));
        if (ok) begin
            wait_ready(20, cyc);
            chk("pix_busy", cyc, 3);
            chk("pix_nwr", wq_a.size(), 1);
            if (wq_a.size() == 1) begin
                e = apply_op(op, ref_img[a], y);
                ref_img[a] = e;
                chk("pix_addr", wq_a[0], a);
                chk("pix_data", wq_d[0], e);
                chk("pix_ram", ram[a], e);
            end
        end else begin
            chk("disc_pulse", {31'b0, Discard_o}, 32'd1);
            chk("disc_ready", {31'b0, CmdReady_o}, 32'd1);
            @(negedge Clock);
            chk("disc_once", {31'b0, Discard_o}, 32'd0);
            chk("disc_nwr", wq_a.size(), 0);
        end
    endtask

    task automatic do_fill(input logic [7:0] d);
        int cyc;
        bit order_ok;
        wq_a.delete(); wq_d.delete();
        CmdOp_i = 2'b11; FillData_i = d; CmdValid_i = 1'b1;
        @(negedge Clock);
        CmdValid_i = 1'b0;
        cyc = 0;
        while (!CmdReady_o && cyc < 3000) begin
            if (cyc == 100) FillData_i = ~d;
            @(negedge Clock);
            cyc++;
        end
        chk("fill_timeout", {31'b0, CmdReady_o}, 32'd1);
        chk("fill_cycles", cyc, 2400);
        chk("fill_nwr", wq_a.size(), 2400);
        order_ok = (wq_a.size() == 2400);
        for (int i = 0; i < wq_a.size(); i++)
            if (wq_a[i] != i || wq_d[i] != d) order_ok = 1'b0;
        chk("fill_seq", {31'b0, order_ok}, 32'd1);
        for (int i = 0; i < 2400; i++) ref_img[i] = d;
        chk("fill_we_low", {31'b0, WriteEnable_o}, 32'd0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 8'($urandom);
            ref_img[i] = ram[i];
        end
        Reset = 1'b1; CmdValid_i = 1'b0; CmdOp_i = '0; X_i = '0; Y_i = '0; FillData_i = '0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("rst_addr", Address_o, 0);
        chk("rst_data", DataToRAM_o, 0);
        chk("rst_we", {31'b0, WriteEnable_o}, 32'd0);
        chk("rst_disc", {31'b0, Discard_o}, 32'd0);
        chk("rst_ready", {31'b0, CmdReady_o}, 32'd1);

        ram[165] = 8'h00; ref_img[165] = 8'h00;
        do_pixel(2'd0, 5, 10);
        chk("set_5_10", ram[165], 8'h04);
        ram[2399] = 8'hFF; ref_img[2399] = 8'hFF;
        do_pixel(2'd1, 159, 119);
        chk("clr_159_119", ram[2399], 8'h7F);

        // Back-to-back toggles with valid held high.
        ram[0] = 8'h10; ref_img[0] = 8'h10;
        wq_a.delete(); wq_d.delete();
        CmdOp_i = 2'd2; X_i = 0; Y_i = 0; CmdValid_i = 1'b1;
        @(negedge Clock);
        wait_ready(20, cyc);
        chk("b2b_busy1", cyc, 3);
        @(negedge Clock);
        chk("b2b_reaccept", {31'b0, CmdReady_o}, 32'd0);
        CmdValid_i = 1'b0;
        wait_ready(20, cyc);
        chk("b2b_nwr", wq_a.size(), 2);
        if (wq_a.size() == 2) begin
            chk("b2b_d0", wq_d[0], 8'h11);
            chk("b2b_d1", wq_d[1], 8'h10);
            chk("b2b_a1", wq_a[1], 0);
        end

        do_pixel(2'd0, 160, 0);
        do_pixel(2'd0, 0, 120);

        do_fill(8'hAA);

        for (int n = 0; n < 40; n++) begin
            do_pixel(2'($urandom_range(0, 2)), $urandom_range(0, 175), $urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) @(negedge Clock);
        end

        // Reset in the middle of a fill.
        CmdOp_i = 2'b11; FillData_i = 8'h5A; CmdValid_i = 1'b1;
        @(negedge Clock);
        CmdValid_i = 1'b0;
        cyc = 0;
        while (Address_o != 12'd1000 && cyc < 2000) begin
            @(negedge Clock);
            cyc++;
        end
        chk("mid_fill_addr", Address_o, 1000);
        Reset = 1'b1;
        @(negedge Clock);
        chk("mid_rst_we", {31'b0, WriteEnable_o}, 32'd0);
        Reset = 1'b0;
        @(negedge Clock);
        chk("mid_rst_ready", {31'b0, CmdReady_o}, 32'd1);
        chk("mid_rst_we2", {31'b0, WriteEnable_o}, 32'd0);
        for (int i = 0; i <= 1000; i++) ref_img[i] = 8'h5A;
        chk("part_last", ram[1000], 8'h5A);
        chk("part_untouched", ram[1001], ref_img[1001]);
        do_pixel(2'd0, 1, 8);
        chk("post_rst_set", ram[161], 8'h5B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
